creator_rst_seq: RTL

- Reset and clock-enable sequencer, directly downstream of the clock manager.
- Runs in the 200 MHz fabric clock domain and consumes the clock manager's LOCKED indication.
- Holds core and peripheral resets asserted until lock has been stable for a programmable time, then releases them in staggered order.
- After release, generates a periodic single-cycle clock-enable strobe for slower datapaths.

---
 rtl/creator_rst_pkg.sv | 20 ++
 rtl/creator_sync2.sv | 24 ++
 rtl/creator_rst_seq.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/creator_rst_pkg.sv
// Shared types, default parameter values and a width helper for the reset sequencer.
package creator_rst_pkg;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_STABLE = 2'd1,
        S_CORE   = 2'd2,
        S_RUN    = 2'd3
    } state_e;

    localparam int unsigned DEF_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_STAGGER_CYCLES = 16;
    localparam int unsigned DEF_CE_DIV         = 8;

    // Counter width able to hold 0..v-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/creator_sync2.sv
// Two-flop synchronizer for a single asynchronous level, synchronously reset to 0.
module creator_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/creator_rst_seq.sv
// Lock-qualified staggered reset release plus post-release clock-enable strobe.
// Optional lock-loss counter enabled by defining CREATOR_RST_SEQ_LOSS_CNT_EN.
module creator_rst_seq
    import creator_rst_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int unsigned STAGGER_CYCLES = DEF_STAGGER_CYCLES,
    parameter int unsigned CE_DIV         = DEF_CE_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       core_rst,
    output logic       periph_rst,
    output logic       ce_out,
    output logic       ready
`ifdef CREATOR_RST_SEQ_LOSS_CNT_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("creator_rst_seq: STABLE_CYCLES must be >= 1");
    end
    if (STAGGER_CYCLES < 1) begin : g_bad_stagger
        $error("creator_rst_seq: STAGGER_CYCLES must be >= 1");
    end
    if (CE_DIV < 2) begin : g_bad_ce_div
        $error("creator_rst_seq: CE_DIV must be >= 2");
    end

    localparam int unsigned StableW  = cnt_width(STABLE_CYCLES);
    localparam int unsigned StaggerW = cnt_width(STAGGER_CYCLES);
    localparam int unsigned CntW     = (StableW > StaggerW) ? StableW : StaggerW;
    localparam int unsigned DivW     = cnt_width(CE_DIV);

    localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] StaggerLast = CntW'(STAGGER_CYCLES - 1);
    localparam logic [DivW-1:0] DivLast     = DivW'(CE_DIV - 1);

    logic locked_s;

    creator_sync2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DivW-1:0] div_q, div_d;
    logic            core_rst_q, core_rst_d;
    logic            periph_rst_q, periph_rst_d;
    logic            ce_q, ce_d;
    logic            ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = '0;

        unique case (state_q)
            S_WAIT: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = S_STABLE;
                end
            end
            S_STABLE: begin
                // Lock loss outranks terminal count.
                if (!locked_s) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == StableLast) begin
                    state_d = S_CORE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            S_CORE: begin
                if (!locked_s) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == StaggerLast) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = S_WAIT;
                end else begin
                    div_d = (div_q == DivLast) ? '0 : div_q + DivW'(1);
                end
            end
            default: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
        endcase

        core_rst_d   = (state_d == S_WAIT) || (state_d == S_STABLE);
        periph_rst_d = (state_d != S_RUN);
        ready_d      = (state_d == S_RUN);
        ce_d         = (state_d == S_RUN) && (state_q == S_RUN) && (div_q == DivLast);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_WAIT;
            cnt_q        <= '0;
            div_q        <= '0;
            core_rst_q   <= 1'b1;
            periph_rst_q <= 1'b1;
            ce_q         <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            core_rst_q   <= core_rst_d;
            periph_rst_q <= periph_rst_d;
            ce_q         <= ce_d;
            ready_q      <= ready_d;
        end
    end

    assign core_rst   = core_rst_q;
    assign periph_rst = periph_rst_q;
    assign ce_out     = ce_q;
    assign ready      = ready_q;

`ifdef CREATOR_RST_SEQ_LOSS_CNT_EN
    logic       loss_event;
    logic [7:0] loss_cnt_q;

    assign loss_event = (state_q != S_WAIT) && !locked_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_cnt_q <= '0;
        end else if (loss_event && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule
